gcd_scheduler: RTL and testbench

//  Shares one gcd engine (ld/u/v in, res/done out) among N_REQ requesters.

---
 rtl/gcd_scheduler_pkg.sv | 14 +
 rtl/gcd_scheduler_if.sv | 20 ++
 rtl/gcd_scheduler_rr_pick.sv | 29 ++
 rtl/gcd_scheduler.sv | 92 +++++++++
 tb/tb_gcd_scheduler.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_scheduler_pkg.sv
// gcd_sched_pkg: scheduler state type, default sizes and round-robin index helpers
package gcd_sched_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;
    localparam int N_REQ_DEF = 4;
    localparam int W_DEF = 8;
    localparam int TIMEOUT_DEF = 512;
    // wrap by compare so N need not be a power of two
    function automatic int rr_idx(input int base, input int off, input int n);
        return (base + off >= n) ? base + off - n : base + off;
    endfunction
    function automatic int rr_next(input int idx, input int n);
        return rr_idx(idx, 1, n);
    endfunction
endpackage

// File: rtl/gcd_scheduler_if.sv
// gcd_scheduler_if: client request/response and engine load/result signals of the scheduler
interface gcd_scheduler_if
    import gcd_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W = W_DEF
);
    logic [N_REQ-1:0] req_valid, req_ready, rsp_valid;
    logic [N_REQ*W-1:0] req_u, req_v;
    logic [W-1:0] rsp_res, gcd_u, gcd_v, gcd_res;
    logic rsp_err, busy, gcd_ld, gcd_done;
    modport master (
        output req_valid, req_u, req_v, gcd_res, gcd_done,
        input req_ready, rsp_valid, rsp_res, rsp_err, busy, gcd_ld, gcd_u, gcd_v
    );
    modport slave (
        input req_valid, req_u, req_v, gcd_res, gcd_done,
        output req_ready, rsp_valid, rsp_res, rsp_err, busy, gcd_ld, gcd_u, gcd_v
    );
endinterface

// File: rtl/gcd_scheduler_rr_pick.sv
// gcd_rr_pick: combinational round-robin picker, first request at or above ptr with wrap
module gcd_rr_pick
    import gcd_sched_pkg::*;
#(
    parameter int N = N_REQ_DEF,
    parameter int IW = $clog2(N)
)(
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] p;
    always_comb begin
        grant = '0;
        idx = '0;
        any = 1'b0;
        p = '0;
        for (int k = 0; k < N; k++) begin
            p = IW'(rr_idx(int'(ptr), k, N));
            if (!any && req[p]) begin
                any = 1'b1;
                idx = p;
                grant[p] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/gcd_scheduler.sv
// gcd_scheduler: shares one gcd engine among N_REQ requesters, round-robin, with done-edge or timeout completion
module gcd_scheduler
    import gcd_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input logic clk,
    input logic resetb,
    gcd_scheduler_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);
    state_t state;
    logic [IW-1:0] ptr, idx, pick_idx;
    logic [N_REQ-1:0] grant, rsp_valid;
    logic [N_REQ-1:0][W-1:0] req_u_a, req_v_a;
    logic [CW-1:0] cnt;
    logic [W-1:0] u_q, v_q, rsp_res;
    logic any, armed, rsp_err, gcd_ld, busy, done_edge;

    gcd_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req(bus.req_valid), .ptr(ptr), .grant(grant), .idx(pick_idx), .any(any)
    );

    assign req_u_a = bus.req_u;
    assign req_v_a = bus.req_v;
    // ready is combinational so a requester that drops valid before this cycle is never accepted
    assign bus.req_ready = (state == IDLE && resetb) ? grant : '0;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_res = rsp_res;
    assign bus.rsp_err = rsp_err;
    assign bus.busy = busy;
    assign bus.gcd_ld = gcd_ld;
    assign bus.gcd_u = u_q;
    assign bus.gcd_v = v_q;
    assign done_edge = armed && bus.gcd_done;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
            ptr <= '0;
            idx <= '0;
            u_q <= '0;
            v_q <= '0;
            cnt <= '0;
            armed <= 1'b0;
            gcd_ld <= 1'b0;
            busy <= 1'b0;
            rsp_valid <= '0;
            rsp_res <= '0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    u_q <= req_u_a[pick_idx];
                    v_q <= req_v_a[pick_idx];
                    idx <= pick_idx;
                    gcd_ld <= 1'b1;
                    busy <= 1'b1;
                    state <= LOAD;
                end
                LOAD: begin
                    gcd_ld <= 1'b0;
                    cnt <= '0;
                    armed <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // a done level left from the previous job only counts after it has been seen low
                    if (!bus.gcd_done) armed <= 1'b1;
                    if (done_edge || cnt == CW'(TIMEOUT - 1)) begin
                        rsp_valid <= N_REQ'(1) << idx;
                        rsp_res <= done_edge ? bus.gcd_res : '0;
                        rsp_err <= !done_edge;
                        state <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    rsp_res <= '0;
                    rsp_err <= 1'b0;
                    ptr <= IW'(rr_next(int'(idx), N_REQ));
                    busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_scheduler.sv
// tb_gcd_scheduler: directed checks of the shared gcd scheduler against a behavioural Euclid engine
module tb_gcd_scheduler;
    logic clk = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

    gcd_scheduler_if #(.N_REQ(4), .W(8)) bus();
    gcd_scheduler #(.N_REQ(4), .W(8), .TIMEOUT(16)) dut (.clk(clk), .resetb(resetb), .bus(bus));

    int total = 0, bad = 0, cyc = 0, glitch = 0;
    logic [3:0] gnt_q[$], rv_q[$];
    int gnt_c[$], ld_c[$], rc_q[$];
    logic [7:0] ldu_q[$], ldv_q[$], rr_q[$];
    logic re_q[$];

    // engine: one Euclid step per cycle; hang never raises done, stale holds the old done for a while after load
    bit hang = 1'b0, stale = 1'b0;
    logic [7:0] ea = '0, eb = '0, e_res = '0;
    logic e_done = 1'b0, e_busy = 1'b0;
    logic [1:0] sdly = '0;
    assign bus.gcd_res = e_res;
    assign bus.gcd_done = e_done;
    always @(posedge clk) begin
        if (bus.gcd_ld) begin
            ea <= bus.gcd_u;
            eb <= bus.gcd_v;
            e_busy <= 1'b1;
            sdly <= stale ? 2'd3 : 2'd0;
            if (!stale) e_done <= 1'b0;
        end else if (sdly != 0) begin
            sdly <= sdly - 2'd1;
            if (sdly == 2'd1) e_done <= 1'b0;
        end else if (e_busy) begin
            if (eb == 0) begin
                e_res <= ea;
                e_done <= !hang;
                e_busy <= 1'b0;
            end else begin
                ea <= eb;
                eb <= ea % eb;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.req_ready != 0) begin gnt_q.push_back(bus.req_ready); gnt_c.push_back(cyc); end
        if (bus.gcd_ld) begin ld_c.push_back(cyc); ldu_q.push_back(bus.gcd_u); ldv_q.push_back(bus.gcd_v); end
        if (bus.rsp_valid != 0) begin
            rv_q.push_back(bus.rsp_valid); rr_q.push_back(bus.rsp_res);
            re_q.push_back(bus.rsp_err); rc_q.push_back(cyc);
        end
        if (bus.busy && ldu_q.size() > 0 && (bus.gcd_u !== ldu_q[$] || bus.gcd_v !== ldv_q[$])) glitch++;
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] u, input logic [7:0] v);
        bus.req_u[i*8 +: 8] = u;
        bus.req_v[i*8 +: 8] = v;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic do_reset();
        go();
        resetb = 1'b0;
        go();
        resetb = 1'b1;
    endtask

    // which: 0 grants, 1 loads, 2 responses; ok when that log reaches n entries within lim cycles
    task automatic wait_q(input int which, input int n, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = ((which == 0) ? gnt_q.size() : (which == 1) ? ld_c.size() : rv_q.size()) >= n;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.busy, bus.gcd_ld} !== 11'd0) begin bad++; $display("FAIL reset_ctl got=%0h want=0", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.busy, bus.gcd_ld}); end
        total++; if ({bus.rsp_res, bus.gcd_u, bus.gcd_v} !== 24'd0) begin bad++; $display("FAIL reset_data got=%0h want=0", {bus.rsp_res, bus.gcd_u, bus.gcd_v}); end
        set_req(2, 8'd5, 8'd5);
        #1;
        total++; if (bus.req_ready !== 4'd0) begin bad++; $display("FAIL reset_ready got=%0h want=0", bus.req_ready); end
        bus.req_valid[2] = 1'b0;
        go();
        resetb = 1'b1;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'd0) begin bad++; $display("FAIL reset_release got busy=%0b rsp=%0h want 0/0", bus.busy, bus.rsp_valid); end
    endtask

    task automatic test_single();
        int g0, l0, r0;
        bit ok;
        g0 = gnt_q.size(); l0 = ld_c.size(); r0 = rv_q.size();
        go();
        set_req(0, 8'd48, 8'd18);
        wait_q(0, g0 + 1, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_grant got=none want=grant"); end
        go();
        bus.req_valid[0] = 1'b0;
        wait_q(2, r0 + 1, 60, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_rsp got=none want=rsp"); end
        repeat (3) @(negedge clk);
        total++; if (gnt_q[g0] !== 4'b0001) begin bad++; $display("FAIL single_ready got=%0h want=1", gnt_q[g0]); end
        total++; if (ld_c.size() - l0 != 1) begin bad++; $display("FAIL single_ldcount got=%0d want=1", ld_c.size() - l0); end
        total++; if (ldu_q[l0] !== 8'd48 || ldv_q[l0] !== 8'd18) begin bad++; $display("FAIL single_ldops got=%0d,%0d want=48,18", ldu_q[l0], ldv_q[l0]); end
        total++; if (ld_c[l0] - gnt_c[g0] != 1) begin bad++; $display("FAIL single_ldlat got=%0d want=1", ld_c[l0] - gnt_c[g0]); end
        total++; if (rv_q[r0] !== 4'b0001) begin bad++; $display("FAIL single_rspv got=%0h want=1", rv_q[r0]); end
        total++; if (rr_q[r0] !== 8'd6 || re_q[r0] !== 1'b0) begin bad++; $display("FAIL single_res got=%0d err=%0b want=6 err=0", rr_q[r0], re_q[r0]); end
        total++; if (rc_q[r0] - ld_c[l0] != 6) begin bad++; $display("FAIL single_lat got=%0d want=6", rc_q[r0] - ld_c[l0]); end
    endtask

    task automatic test_two();
        int g0, l0, r0, gl;
        bit ok;
        do_reset();
        g0 = gnt_q.size(); l0 = ld_c.size(); r0 = rv_q.size(); gl = glitch;
        set_req(0, 8'd12, 8'd8);
        set_req(2, 8'd35, 8'd14);
        wait_q(0, g0 + 1, 20, ok);
        go();
        bus.req_valid[0] = 1'b0;
        wait_q(0, g0 + 2, 40, ok);
        go();
        bus.req_valid[2] = 1'b0;
        wait_q(2, r0 + 2, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL two_rsp got=%0d want=2", rv_q.size() - r0); end
        @(negedge clk);
        total++; if (gnt_q[g0] !== 4'b0001 || gnt_q[g0+1] !== 4'b0100) begin bad++; $display("FAIL two_order got=%0h,%0h want=1,4", gnt_q[g0], gnt_q[g0+1]); end
        total++; if (rv_q[r0] !== 4'b0001 || rr_q[r0] !== 8'd4) begin bad++; $display("FAIL two_rsp0 got=%0h/%0d want=1/4", rv_q[r0], rr_q[r0]); end
        total++; if (rv_q[r0+1] !== 4'b0100 || rr_q[r0+1] !== 8'd7) begin bad++; $display("FAIL two_rsp2 got=%0h/%0d want=4/7", rv_q[r0+1], rr_q[r0+1]); end
        total++; if (gnt_c[g0+1] - rc_q[r0] != 1) begin bad++; $display("FAIL two_gap got=%0d want=1", gnt_c[g0+1] - rc_q[r0]); end
        total++; if (ldu_q[l0+1] !== 8'd35 || ldv_q[l0+1] !== 8'd14) begin bad++; $display("FAIL two_ldops got=%0d,%0d want=35,14", ldu_q[l0+1], ldv_q[l0+1]); end
        total++; if (glitch != gl) begin bad++; $display("FAIL two_stable got=%0d want=%0d", glitch, gl); end
        total++; if (bus.gcd_u !== 8'd35 || bus.gcd_v !== 8'd14 || bus.busy !== 1'b0) begin bad++; $display("FAIL two_hold got=%0d,%0d busy=%0b want=35,14 busy=0", bus.gcd_u, bus.gcd_v, bus.busy); end
    endtask

    task automatic test_all();
        int g0, r0;
        bit ok;
        logic [7:0] exp_r[4];
        logic [3:0] e;
        exp_r = '{8'd6, 8'd4, 8'd7, 8'd9};
        do_reset();
        g0 = gnt_q.size(); r0 = rv_q.size();
        set_req(0, 8'd48, 8'd18);
        set_req(1, 8'd12, 8'd8);
        set_req(2, 8'd35, 8'd14);
        set_req(3, 8'd0, 8'd9);
        wait_q(2, r0 + 8, 200, ok);
        go();
        bus.req_valid = '0;
        total++; if (!ok) begin bad++; $display("FAIL all_rsp got=%0d want=8", rv_q.size() - r0); end
        repeat (4) @(negedge clk);
        total++; if (gnt_q.size() != g0 + 8) begin bad++; $display("FAIL all_count got=%0d want=8", gnt_q.size() - g0); end
        for (int i = 0; i < 8; i++) begin
            e = 4'b0001 << (i % 4);
            total++; if (gnt_q[g0+i] !== e) begin bad++; $display("FAIL all_grant%0d got=%0h want=%0h", i, gnt_q[g0+i], e); end
            total++; if (rv_q[r0+i] !== e) begin bad++; $display("FAIL all_rspv%0d got=%0h want=%0h", i, rv_q[r0+i], e); end
            total++; if (rr_q[r0+i] !== exp_r[i%4]) begin bad++; $display("FAIL all_res%0d got=%0d want=%0d", i, rr_q[r0+i], exp_r[i%4]); end
        end
    endtask

    task automatic test_timeout();
        int g0, l0, r0;
        bit ok;
        hang = 1'b1;
        g0 = gnt_q.size(); l0 = ld_c.size(); r0 = rv_q.size();
        go();
        set_req(1, 8'd20, 8'd8);
        wait_q(0, g0 + 1, 20, ok);
        go();
        bus.req_valid[1] = 1'b0;
        wait_q(2, r0 + 1, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_rsp got=none want=rsp"); end
        total++; if (rv_q[r0] !== 4'b0010 || rr_q[r0] !== 8'd0 || re_q[r0] !== 1'b1) begin bad++; $display("FAIL to_vals got=%0h/%0d/%0b want=2/0/1", rv_q[r0], rr_q[r0], re_q[r0]); end
        total++; if (rc_q[r0] - ld_c[l0] != 17) begin bad++; $display("FAIL to_lat got=%0d want=17", rc_q[r0] - ld_c[l0]); end
        hang = 1'b0;
        go();
        set_req(1, 8'd20, 8'd8);
        wait_q(0, g0 + 2, 20, ok);
        go();
        bus.req_valid[1] = 1'b0;
        wait_q(2, r0 + 2, 40, ok);
        total++; if (rv_q[r0+1] !== 4'b0010 || rr_q[r0+1] !== 8'd4 || re_q[r0+1] !== 1'b0) begin bad++; $display("FAIL to_after got=%0h/%0d/%0b want=2/4/0", rv_q[r0+1], rr_q[r0+1], re_q[r0+1]); end
    endtask

    task automatic test_reset_mid();
        int g0, l0, r0;
        bit ok;
        g0 = gnt_q.size(); l0 = ld_c.size(); r0 = rv_q.size();
        go();
        set_req(1, 8'd255, 8'd17);
        wait_q(1, l0 + 1, 20, ok);
        bus.req_valid[1] = 1'b0;
        go();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%0b want=1", bus.busy); end
        resetb = 1'b0;
        #1;
        total++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.busy, bus.gcd_ld} !== 11'd0) begin bad++; $display("FAIL mid_ctl got=%0h want=0", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.busy, bus.gcd_ld}); end
        total++; if ({bus.rsp_res, bus.gcd_u, bus.gcd_v} !== 24'd0) begin bad++; $display("FAIL mid_data got=%0h want=0", {bus.rsp_res, bus.gcd_u, bus.gcd_v}); end
        repeat (3) go();
        resetb = 1'b1;
        repeat (8) @(negedge clk);
        total++; if (rv_q.size() != r0) begin bad++; $display("FAIL mid_norsp got=%0d want=0", rv_q.size() - r0); end
        go();
        set_req(1, 8'd255, 8'd17);
        wait_q(0, g0 + 2, 20, ok);
        go();
        bus.req_valid[1] = 1'b0;
        wait_q(2, r0 + 1, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_rsp got=none want=rsp"); end
        total++; if (rv_q[r0] !== 4'b0010 || rr_q[r0] !== 8'd17 || re_q[r0] !== 1'b0) begin bad++; $display("FAIL mid_res got=%0h/%0d/%0b want=2/17/0", rv_q[r0], rr_q[r0], re_q[r0]); end
    endtask

    task automatic test_stale();
        int g0, l0, r0;
        bit ok;
        g0 = gnt_q.size(); r0 = rv_q.size();
        go();
        set_req(0, 8'd12, 8'd8);
        wait_q(0, g0 + 1, 20, ok);
        go();
        bus.req_valid[0] = 1'b0;
        wait_q(2, r0 + 1, 40, ok);
        total++; if (rr_q[r0] !== 8'd4) begin bad++; $display("FAIL stale_prev got=%0d want=4", rr_q[r0]); end
        stale = 1'b1;
        l0 = ld_c.size();
        go();
        set_req(3, 8'd0, 8'd9);
        wait_q(0, g0 + 2, 20, ok);
        go();
        bus.req_valid[3] = 1'b0;
        wait_q(2, r0 + 2, 40, ok);
        stale = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL stale_rsp got=none want=rsp"); end
        total++; if (rv_q[r0+1] !== 4'b1000 || rr_q[r0+1] !== 8'd9 || re_q[r0+1] !== 1'b0) begin bad++; $display("FAIL stale_res got=%0h/%0d/%0b want=8/9/0", rv_q[r0+1], rr_q[r0+1], re_q[r0+1]); end
        total++; if (rc_q[r0+1] - ld_c[l0] != 7) begin bad++; $display("FAIL stale_lat got=%0d want=7", rc_q[r0+1] - ld_c[l0]); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_u = '0;
        bus.req_v = '0;
        test_reset();
        test_single();
        test_two();
        test_all();
        test_timeout();
        test_reset_mid();
        test_stale();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
